// File: rtl/instr_sequencer_pkg.sv
// Opcodes, instruction field positions and FSM states shared by the Jericalla sequencer.
// The StWaitStep state exists only when SEQ_STEP_EN is defined.
package instr_sequencer_pkg;

  localparam int unsigned WordW   = 20;
  localparam int unsigned OpMsb   = 19;
  localparam int unsigned OpLsb   = 16;
  localparam int unsigned RsvdBit = 15;
  localparam int unsigned Rd1Msb  = 14;
  localparam int unsigned Rd1Lsb  = 10;
  localparam int unsigned Rd2Msb  = 9;
  localparam int unsigned Rd2Lsb  = 5;
  localparam int unsigned WrMsb   = 4;
  localparam int unsigned WrLsb   = 0;

  typedef enum logic [3:0] {
    OpAnd  = 4'h0,
    OpOr   = 4'h1,
    OpAdd  = 4'h2,
    OpSub  = 4'h3,
    OpSlt  = 4'h4,
    OpNor  = 4'h5,
    OpSw   = 4'h6,
    OpLw   = 4'h7,
    OpHalt = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {ClsAlu, ClsMem, ClsIllegal, ClsHalt} op_class_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StExec,
    StHalt
`ifdef SEQ_STEP_EN
    , StWaitStep
`endif
  } state_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    if (op <= OpNor) return ClsAlu;
    if (op == OpSw || op == OpLw) return ClsMem;
    if (op == OpHalt) return ClsHalt;
    return ClsIllegal;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory read port plus the issue bundle towards unidad_control and the
// register bank; master is the sequencer side.
interface instr_sequencer_if
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = 6
);
  logic              im_en;
  logic [PC_W-1:0]   im_addr;
  logic [WordW-1:0]  im_rdata;
  logic              mem_ack;
  logic [3:0]        opcode;
  logic [4:0]        rd_addr1;
  logic [4:0]        rd_addr2;
  logic [4:0]        wr_addr;
  logic              instr_valid;

  modport master (
    output im_en, im_addr, opcode, rd_addr1, rd_addr2, wr_addr, instr_valid,
    input  im_rdata, mem_ack
  );

  modport slave (
    input  im_en, im_addr, opcode, rd_addr1, rd_addr2, wr_addr, instr_valid,
    output im_rdata, mem_ack
  );
endinterface

// File: rtl/instr_sequencer_pc_counter.sv
// Program counter with synchronous clear, increment and a flag for the last program word.
module instr_sequencer_pc_counter #(
  parameter int unsigned Width = 6,
  parameter int unsigned Last  = 63
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] count,
  output logic             at_end
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count  = count_q;
  assign at_end = (count_q == Width'(Last));

endmodule

// File: rtl/instr_sequencer.sv
// Jericalla fetch/issue engine: fetch, latch, issue one instruction at a time, stop on HALT
// or at the last program word. Defining SEQ_STEP_EN adds the step port and WAIT_STEP state.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned PC_W     = 6,
  parameter int unsigned PROG_LEN = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
`ifdef SEQ_STEP_EN
  input  logic                step,
`endif
  instr_sequencer_if.master   bus,
  output logic [PC_W-1:0]     pc,
  output logic                busy,
  output logic                halted,
  output logic [7:0]          illegal_cnt
);

  state_e    state_q;
  logic [3:0] ir_op_q;
  logic      im_en_q, instr_valid_q, busy_q, halted_q;
  logic [3:0] opcode_q;
  logic [4:0] rd_addr1_q, rd_addr2_q, wr_addr_q;
  logic [7:0] illegal_cnt_q;

  op_class_e ir_cls, lat_cls;
  logic [3:0] lat_op;
  logic      restart, done, pc_clr, pc_inc, pc_at_end;
  logic      unused_rsvd;

  assign unused_rsvd = bus.im_rdata[RsvdBit];
  assign lat_op      = bus.im_rdata[OpMsb:OpLsb];
  assign lat_cls     = op_class(lat_op);
  assign ir_cls      = op_class(ir_op_q);

  always_comb begin
    restart = start && (state_q == StIdle || state_q == StHalt);
    done    = 1'b0;
    if (state_q == StExec) begin
      unique case (ir_cls)
        ClsAlu, ClsIllegal: done = 1'b1;
        ClsMem:             done = bus.mem_ack;
        ClsHalt:            done = 1'b0;
      endcase
    end
    pc_clr = restart;
    pc_inc = done && !pc_at_end;
  end

  instr_sequencer_pc_counter #(
    .Width (PC_W),
    .Last  (PROG_LEN - 1)
  ) u_pc_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (pc_clr),
    .inc    (pc_inc),
    .count  (pc),
    .at_end (pc_at_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ir_op_q       <= '0;
      im_en_q       <= 1'b0;
      instr_valid_q <= 1'b0;
      opcode_q      <= '0;
      rd_addr1_q    <= '0;
      rd_addr2_q    <= '0;
      wr_addr_q     <= '0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle, StHalt: begin
          if (start) begin
            state_q  <= StFetch;
            im_en_q  <= 1'b1;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        StFetch: begin
          state_q <= StLatch;
          im_en_q <= 1'b0;
        end
        StLatch: begin
          ir_op_q <= lat_op;
          state_q <= StExec;
          // Only ALU and memory ops are presented; everything else keeps the fields at zero.
          if (lat_cls == ClsAlu || lat_cls == ClsMem) begin
            instr_valid_q <= 1'b1;
            opcode_q      <= lat_op;
            rd_addr1_q    <= bus.im_rdata[Rd1Msb:Rd1Lsb];
            rd_addr2_q    <= bus.im_rdata[Rd2Msb:Rd2Lsb];
            wr_addr_q     <= bus.im_rdata[WrMsb:WrLsb];
          end
        end
        StExec: begin
          if (ir_cls == ClsIllegal && illegal_cnt_q != 8'hFF) begin
            illegal_cnt_q <= illegal_cnt_q + 8'd1;
          end
          if (ir_cls == ClsHalt || (done && pc_at_end)) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
            busy_q   <= 1'b0;
          end else if (done) begin
`ifdef SEQ_STEP_EN
            state_q <= StWaitStep;
`else
            state_q <= StFetch;
            im_en_q <= 1'b1;
`endif
          end
          if (done) begin
            instr_valid_q <= 1'b0;
            opcode_q      <= '0;
            rd_addr1_q    <= '0;
            rd_addr2_q    <= '0;
            wr_addr_q     <= '0;
          end
        end
`ifdef SEQ_STEP_EN
        StWaitStep: begin
          if (step) begin
            state_q <= StFetch;
            im_en_q <= 1'b1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.im_en       = im_en_q;
  assign bus.im_addr     = pc;
  assign bus.instr_valid = instr_valid_q;
  assign bus.opcode      = opcode_q;
  assign bus.rd_addr1    = rd_addr1_q;
  assign bus.rd_addr2    = rd_addr2_q;
  assign bus.wr_addr     = wr_addr_q;
  assign busy            = busy_q;
  assign halted          = halted_q;
  assign illegal_cnt     = illegal_cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: program-level reference model plus per-cycle
// scoreboard of issued fields and fetch addresses.
module tb_instr_sequencer;
  localparam int unsigned PC_W     = 6;
  localparam int unsigned PROG_LEN = 64;
  localparam logic [19:0] AddW     = 20'h20443;
  localparam logic [19:0] HaltW    = 20'hF0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
`ifdef SEQ_STEP_EN
  logic step = 1'b1;
`endif
  logic [PC_W-1:0] pc;
  logic busy, halted;
  logic [7:0] illegal_cnt;

  instr_sequencer_if #(.PC_W(PC_W)) bus ();

  instr_sequencer #(.PC_W(PC_W), .PROG_LEN(PROG_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
`ifdef SEQ_STEP_EN
    .step        (step),
`endif
    .bus         (bus),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, cyc = 0;
  int start_cyc = 0, first_imen = -1, first_valid = -1, n_valid = 0;
  int wait_cnt = 0, cur_delay = 0, ack_delay = 0;
  bit rand_ack = 1'b1;
  logic [18:0] exp_q[$];
  int exp_fetch[$];
  int exp_ill = 0, exp_pc = 0;
  logic [19:0] prog [PROG_LEN];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({bus.im_en, bus.im_addr, bus.opcode, bus.rd_addr1, bus.rd_addr2, bus.wr_addr,
                bus.instr_valid, pc, busy, halted, illegal_cnt});
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous instruction memory: data valid the cycle after im_en.
  always @(posedge clk) if (bus.im_en) bus.im_rdata <= prog[bus.im_addr];

  // Data-RAM ack driver and scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      wait_cnt = 0;
      bus.mem_ack = 1'b0;
    end else begin
      if (bus.instr_valid && (bus.opcode == 4'h6 || bus.opcode == 4'h7)) begin
        if (wait_cnt == 0) cur_delay = rand_ack ? int'($urandom_range(0, 3)) : ack_delay;
        wait_cnt++;
        bus.mem_ack = (wait_cnt > cur_delay);
      end else begin
        wait_cnt = 0;
        bus.mem_ack = 1'($urandom_range(0, 1));
      end
      if (bus.instr_valid) begin
        n_valid++;
        if (first_valid < 0) first_valid = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 64'(bus.instr_valid), 64'd0);
        end else begin
          check("issue_fields", 64'({bus.opcode, bus.rd_addr1, bus.rd_addr2, bus.wr_addr}),
                64'(exp_q[0]));
          if (exp_q[0][18:15] <= 4'h5 || bus.mem_ack) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_fields_zero", 64'({bus.opcode, bus.rd_addr1, bus.rd_addr2, bus.wr_addr}),
              64'd0);
      end
      if (bus.im_en) begin
        if (first_imen < 0) first_imen = cyc;
        if (exp_fetch.size() == 0) check("unexpected_fetch", 64'(bus.im_en), 64'd0);
        else check("fetch_addr", 64'(bus.im_addr), 64'(exp_fetch.pop_front()));
      end
    end
  end

  // Walk the program by the architectural rules to get issues, fetches, final pc and count.
  task automatic build_model();
    int p = 0;
    logic [19:0] w;
    logic [3:0] op;
    exp_q.delete();
    exp_fetch.delete();
    forever begin
      w = prog[p];
      op = w[19:16];
      exp_fetch.push_back(p);
      if (op == 4'hF) break;
      if (op <= 4'h7) exp_q.push_back({op, w[14:10], w[9:5], w[4:0]});
      else if (exp_ill < 255) exp_ill++;
      if (p == PROG_LEN - 1) break;
      p++;
    end
    exp_pc = p;
  endtask

  task automatic rand_prog(input bit allow_halt, input bit all_illegal);
    logic [31:0] r;
    logic [3:0] op;
    for (int i = 0; i < PROG_LEN; i++) begin
      r = $urandom;
      if (all_illegal) op = 4'($urandom_range(8, 14));
      else if (allow_halt && $urandom_range(0, 49) == 0) op = 4'hF;
      else if ($urandom_range(0, 5) == 0) op = 4'($urandom_range(8, 14));
      else op = 4'($urandom_range(0, 7));
      prog[i] = {op, r[15:0]};
    end
  endtask

  task automatic pulse_start();
    first_imen = -1;
    first_valid = -1;
    n_valid = 0;
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    check("restart_state", 64'({halted, busy, pc}), 64'({1'b0, 1'b1, 6'd0}));
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (halted !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_halt_reached"}, 64'(halted), 64'd1);
  endtask

  task automatic wait_valid_op(input logic [3:0] op, input string name);
    int n = 0;
    while (!(bus.instr_valid === 1'b1 && bus.opcode === op) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_issue_seen"}, 64'(bus.instr_valid && bus.opcode == op), 64'd1);
  endtask

  task automatic final_checks(input string name);
    check({name, "_pc"}, 64'(pc), 64'(exp_pc));
    check({name, "_illegal_cnt"}, 64'(illegal_cnt), 64'(exp_ill));
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_issues_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_fetches_left"}, 64'(exp_fetch.size()), 64'd0);
  endtask

  task automatic run_prog(input string name);
    build_model();
    pulse_start();
    wait_halt(name);
    final_checks(name);
  endtask

  initial begin
    for (int i = 0; i < PROG_LEN; i++) prog[i] = HaltW;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", out_vec(), 64'd0);
    rst_n = 1'b1;
    exp_ill = 0;

    // ADD then HALT: single issue, fixed latency.
    prog[0] = AddW;
    prog[1] = HaltW;
    build_model();
    check("model_add_fields", 64'(exp_q[0]), 64'({4'h2, 5'd1, 5'd2, 5'd3}));
    pulse_start();
    wait_halt("add");
    final_checks("add");
    check("add_imen_latency", 64'(first_imen - start_cyc), 64'd1);
    check("add_valid_latency", 64'(first_valid - start_cyc), 64'd3);
    check("add_valid_cycles", 64'(n_valid), 64'd1);
    check("add_pc_literal", 64'(pc), 64'd1);

    // LW held for 5 cycles without ack; start during EXEC must be ignored.
    rand_ack = 1'b0;
    ack_delay = 5;
    prog[0] = AddW;
    prog[1] = 20'h70C41;
    prog[2] = HaltW;
    build_model();
    check("model_lw_fields", 64'(exp_q[1]), 64'({4'h7, 5'd3, 5'd2, 5'd1}));
    pulse_start();
    wait_valid_op(4'h7, "lw");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored_pc", 64'(pc), 64'd1);
    check("start_ignored_busy_valid", 64'({busy, bus.instr_valid}), 64'b11);
    wait_halt("lw");
    final_checks("lw");
    check("lw_valid_cycles", 64'(n_valid), 64'd7);
    check("lw_pc_literal", 64'(pc), 64'd2);
    rand_ack = 1'b1;

    // Illegal words between two ADDs.
    prog[0] = AddW;
    prog[1] = 20'h81234;
    prog[2] = 20'hEABCD;
    prog[3] = AddW;
    prog[4] = HaltW;
    run_prog("illegal");
    check("illegal_cnt_literal", 64'(illegal_cnt), 64'd2);
    check("illegal_valid_cycles", 64'(n_valid), 64'd2);

    // 320 illegal words saturate the counter; each run also ends at the last word.
    rand_prog(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) run_prog("saturate");
    check("saturate_literal", 64'(illegal_cnt), 64'd255);
    check("end_pc_literal", 64'(pc), 64'd63);

    // Asynchronous reset while a SW waits for its ack.
    rand_ack = 1'b0;
    ack_delay = 30;
    prog[0] = AddW;
    prog[1] = 20'h60C41;
    prog[2] = HaltW;
    build_model();
    pulse_start();
    wait_valid_op(4'h6, "sw");
    #2 rst_n = 1'b0;
    #1 check("reset_mid_sw", out_vec(), 64'd0);
    exp_q.delete();
    exp_fetch.delete();
    exp_ill = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rand_ack = 1'b1;

    // Random programs, alternating with and without HALT words.
    for (int k = 0; k < 6; k++) begin
      rand_prog(1'(k % 2), 1'b0);
      run_prog("random");
    end
    rand_prog(1'b0, 1'b0);
    run_prog("no_halt");
    check("no_halt_pc_literal", 64'(pc), 64'd63);
    check("no_halt_halted_literal", 64'(halted), 64'd1);

`ifdef SEQ_STEP_EN
    step = 1'b0;
    prog[0] = AddW;
    prog[1] = AddW;
    prog[2] = AddW;
    prog[3] = HaltW;
    build_model();
    pulse_start();
    repeat (15) @(negedge clk);
    check("step_parked_issues", 64'(n_valid), 64'd1);
    check("step_parked_busy", 64'({busy, halted}), 64'b10);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (15) @(negedge clk);
    check("step_one_issue", 64'(n_valid), 64'd2);
    step = 1'b1;
    wait_halt("step");
    final_checks("step");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction fetch and issue engine for the Jericalla datapath. Holds the program counter, reads 20-bit instruction words from a synchronous instruction memory, and presents opcode and register fields to `unidad_control` and the register bank. Issues one instruction at a time, holds LW/SW until the data RAM acknowledges, and stops on a HALT opcode or at the end of the program.

## Interface
Parameters:
- PC_W, 6: program counter / instruction memory address width.
- PROG_LEN, 64: number of valid program words; must be ≤ 2^PC_W.

Ports:
- Reset and clock: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin execution at pc=0; ignored while busy.
- im_en  out  1  instruction memory read enable.
- im_addr  out  PC_W  instruction memory address.
- im_rdata  in  20  instruction word; valid the cycle after im_en.
- mem_ack  in  1  data RAM has completed the current LW/SW.
- opcode  out  4  to unidad_control `instruction`.
- rd_addr1  out  5  register bank read address 1.
- rd_addr2  out  5  register bank read address 2.
- wr_addr  out  5  register bank write address.
- instr_valid  out  1  opcode and address fields are being issued this cycle.
- pc  out  PC_W  current program counter.
- busy  out  1  not IDLE and not HALT.
- halted  out  1  stopped on HALT opcode or end of program.
- illegal_cnt  out  8  saturating count of skipped illegal opcodes.
- step  in  1  single-step advance; present only with SEQ_STEP_EN.

## Operation
- Word format: [19:16] opcode, [15] reserved (ignored), [14:10] rd_addr1, [9:5] rd_addr2, [4:0] wr_addr.
- Opcode classes: 0000–0101 ALU (AND, OR, ADD, SUB, SLT, NOR); 0110 SW; 0111 LW; 1111 HALT; 1000–1110 illegal.
- FSM states:
  - IDLE: start=1 clears pc to 0 and moves to FETCH.
  - FETCH: im_en=1, im_addr=pc; moves to LATCH.
  - LATCH: captures im_rdata into the instruction register; moves to EXEC.
  - EXEC, ALU op: instr_valid=1 for one cycle, then the instruction completes.
  - EXEC, LW/SW: instr_valid held at 1 and fields stable until mem_ack=1; completes in that cycle.
  - EXEC, illegal: instr_valid=0; illegal_cnt increments, saturating at 255; the instruction completes.
  - EXEC, HALT: instr_valid=0; moves to HALT and sets halted=1; pc is not advanced.
  - HALT: start=1 clears pc, clears halted, moves to FETCH.
- On completion:
  - If pc == PROG_LEN-1, go to HALT with halted=1 and pc unchanged.
  - Otherwise pc increments by 1 and the FSM goes to FETCH.
- opcode and address outputs are driven from the instruction register. They are 0 whenever instr_valid=0, so unidad_control never sees stale fields.
- mem_ack is ignored outside an LW/SW EXEC. start is ignored in FETCH, LATCH and EXEC.
- illegal_cnt clears only on reset.

## Timing
- Reset: asynchronous to IDLE. All outputs are 0: pc, im_en, im_addr, opcode, all address outputs, instr_valid, busy, halted, illegal_cnt.
- Reset mid-instruction aborts immediately. A pending LW/SW is dropped; the RAM side must also be reset.
- Latency: start sampled in cycle t → im_en in t+1 → instr_valid in t+3.
- ALU-op throughput: one instruction per 3 cycles.
- LW/SW: 3 cycles plus the number of cycles until mem_ack. A mem_ack present in the first EXEC cycle completes it in that cycle.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- SEQ_STEP_EN defined:
  - The `step` port exists.
  - After every completion that does not halt, the FSM enters WAIT_STEP with busy=1.
  - A cycle with step=1 moves WAIT_STEP to FETCH.
  - A step held high advances one instruction per completion; no edge detection.
- SEQ_STEP_EN undefined: no `step` port and no WAIT_STEP state; the sequencer runs freely.

## Structure
- Shared include `jericalla_defs.vh` holds:
  - opcode constants (OP_AND … OP_LW, OP_HALT);
  - instruction field bit positions;
  - the 20-bit word width;
  - FSM state encodings.
- unidad_control uses the same opcode constants.
- One sub-module, `pc_counter`: a PC_W-bit counter with clear, increment and at-end flag.

## Test plan
- Reset, then program [0x20443 (ADD r1,r2→r3), 0xF0000] and pulse start → exactly one instr_valid pulse with opcode=0010, rd1=1, rd2=2, wr=3, 3 cycles after start. Then halted=1, pc=1.
- LW word 0x70C41 with mem_ack held low for 5 cycles → instr_valid and fields stay stable for 6 cycles and drop the cycle after mem_ack. pc then advances by 1.
- Illegal opcodes 0x8xxxx, 0xExxxx between two ADDs → no instr_valid for the illegal words, illegal_cnt=2, both ADDs issued. 300 illegal words → illegal_cnt=255.
- PROG_LEN=4 with no HALT word → four issues, then halted=1, pc=3. A start in HALT restarts at pc=0.
- Assert rst_n low during a SW EXEC → all outputs 0 asynchronously. start is ignored while busy, with no pc change.
- With SEQ_STEP_EN, step low → sequencer parks in WAIT_STEP after the first instruction. One step pulse → exactly one further issue.
